// File: rtl/fmul8_seq.sv
// Sequential minifloat multiplier (1s/3e bias 3/4f, hidden 1) built on a 5-cycle shift-add loop.
// The result is registered and held under valid/ready backpressure until it is consumed.
module fmul8_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] p,
   output logic       busy
);

   typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

   state_e      state_q, state_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  b_q, b_d;
   logic [9:0]  acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  p_q, p_d;
   logic        out_valid_q, out_valid_d;

   logic [4:0]  mb;
   logic [9:0]  addend;
   logic [4:0]  e_sum;
   logic [3:0]  frac;
   logic [2:0]  e_field;
   logic        sign;
   logic        op_zero;
   logic [7:0]  p_norm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (in_valid) state_d = StMul;
         StMul:  if (cnt_q == 3'd4) state_d = StNorm;
         StNorm: state_d = StDone;
         StDone: if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready = (state_q == StIdle);
      busy     = (state_q != StIdle);
   end

   // Biased exponent sum kept unsigned: true exponent is e_sum - 3.
   always_comb begin
      mb      = {1'b1, b_q[3:0]};
      addend  = {5'b0, 1'b1, a_q[3:0]} << cnt_q;
      sign    = a_q[7] ^ b_q[7];
      op_zero = (a_q[6:0] == 7'h00) || (b_q[6:0] == 7'h00);
      e_sum   = {2'b00, a_q[6:4]} + {2'b00, b_q[6:4]} + {4'b0000, acc_q[9]};
      frac    = acc_q[9] ? acc_q[8:5] : acc_q[7:4];
      e_field = 3'(e_sum - 5'd3);
      if (op_zero || (e_sum < 5'd3)) begin
         p_norm = 8'h00;
      end else if (e_sum > 5'd10) begin
         p_norm = {sign, 7'h7F};
      end else if ((e_field == 3'd0) && (frac == 4'd0)) begin
         p_norm = 8'h00;
      end else begin
         p_norm = {sign, e_field, frac};
      end
   end

   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      p_d         = p_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d   = a;
               b_d   = b;
               acc_d = 10'd0;
               cnt_d = 3'd0;
            end
         end
         StMul: begin
            if (mb[cnt_q]) acc_d = acc_q + addend;
            cnt_d = cnt_q + 3'd1;
         end
         StNorm: begin
            p_d         = p_norm;
            out_valid_d = 1'b1;
         end
         StDone: begin
            if (out_ready) out_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         acc_q       <= 10'd0;
         cnt_q       <= 3'd0;
         p_q         <= 8'h00;
         out_valid_q <= 1'b0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         p_q         <= p_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign p         = p_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fmul8_seq.sv
// Directed bench for fmul8_seq: hand-computed products, latency, backpressure, reset abort
// and back-to-back streaming.
module tb_fmul8_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] p;
   logic       busy;

   int checks;
   int passed;

   fmul8_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sample/drive 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one operation with out_ready=1 and check product, latency and release.
   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] exp_p);
      int lat;
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      step();
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      check({tag, "_lat"}, lat, 7);
      check({tag, "_p"}, int'(p), int'(exp_p));
      check({tag, "_in_ready_done"}, int'(in_ready), 0);
      step();
      check({tag, "_released"}, int'({out_valid, in_ready}), 1);
   endtask

   initial begin
      int lat;
      int acc_cyc [2];
      int out_val [2];
      int n_acc;
      int n_out;
      int cyc;
      logic stale;

      checks    = 0;
      passed    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = 8'h00;
      b         = 8'h00;
      #12;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_p", int'(p), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      step();

      run_op("one_x_one", 8'h30, 8'h30, 8'h30);
      run_op("carry", 8'h38, 8'h38, 8'h42);
      run_op("sign", 8'hC0, 8'h48, 8'hD8);
      run_op("saturate", 8'h7F, 8'h7F, 8'h7F);
      run_op("underflow", 8'h10, 8'h10, 8'h00);
      run_op("zero_op", 8'h80, 8'h48, 8'h00);

      // Backpressure with operand toggling during MUL: 1.5*2 x 1.5*2 = 9.0 -> 0x62.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = 8'h48;
      b         = 8'h48;
      step();
      in_valid = 1'b0;
      a        = 8'hFF;
      b        = 8'h00;
      step();
      a = 8'h10;
      b = 8'h7F;
      step();
      a = 8'h00;
      b = 8'hFF;
      lat = 3;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      check("bp_lat", lat, 7);
      for (int i = 0; i < 4; i++) begin
         check("bp_p_hold", int'(p), 8'h62);
         check("bp_flags", int'({out_valid, in_ready, busy}), 3'b101);
         step();
      end
      check("bp_p_still", int'(p), 8'h62);
      out_ready = 1'b1;
      step();
      check("bp_release", int'({out_valid, in_ready, busy}), 3'b010);

      // Reset abort in MUL cycle 3.
      in_valid = 1'b1;
      a        = 8'h38;
      b        = 8'h38;
      step();
      in_valid = 1'b0;
      step();
      step();
      check("pre_rst_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_p", int'(p), 0);
      check("abort_in_ready", int'(in_ready), 1);
      #1 rst_n = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid || busy) stale = 1'b1;
      end
      check("no_stale_output", int'(stale), 0);

      // Back-to-back stream with in_valid held high.
      in_valid = 1'b1;
      a        = 8'h30;
      b        = 8'h30;
      n_acc    = 0;
      n_out    = 0;
      cyc      = 0;
      acc_cyc  = '{0, 0};
      out_val  = '{0, 0};
      while (cyc < 30 && n_out < 2) begin
         if (in_valid && in_ready && n_acc < 2) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
         end
         step();
         cyc++;
         if (n_acc == 1) begin
            a = 8'h38;
            b = 8'h38;
         end else if (n_acc == 2) begin
            in_valid = 1'b0;
         end
         if (out_valid && n_out < 2) begin
            out_val[n_out] = int'(p);
            n_out++;
         end
      end
      in_valid = 1'b0;
      check("stream_accepts", n_acc, 2);
      check("stream_outputs", n_out, 2);
      check("stream_interval", acc_cyc[1] - acc_cyc[0], 8);
      check("stream_p0", out_val[0], 8'h30);
      check("stream_p1", out_val[1], 8'h42);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/fmul8_seq.md
# fmul8_seq

Sequential multi-cycle multiplier for the 8-bit minifloat format used by the matrix-multiplication datapath. The format is 1 sign, 3 exponent bits with bias 3, and 4 fraction bits with a hidden 1. The block sits directly upstream of the minifloat adder: each product it emits is one addend of a dot-product term. It multiplies the 5-bit significands with a shift-add loop and uses valid/ready handshakes on both sides.

## Interface
Parameters: none (format fixed: S[7], E[6:4], F[3:0]).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands a/b present
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  8  operand A (minifloat)
- b  in  8  operand B (minifloat)
- out_valid  out  1  product p valid
- out_ready  in  1  downstream consumes p
- p  out  8  product (minifloat)
- busy  out  1  high whenever state != IDLE

## Operation
- Encoding:
  - value = (-1)^S × 1.F × 2^(E-3).
  - Any word with bits[6:0]==0 is zero.
  - Canonical zero output is 8'h00.
- FSM states: IDLE, MUL, NORM, DONE.
  - IDLE -> MUL on in_valid && in_ready.
    - Latch a and b.
    - Clear the 10-bit accumulator.
    - Load the 3-bit counter with 0.
  - MUL: 5 cycles. Each cycle:
    - If multiplier bit[cnt] of mb = {1,Fb} is set, acc += {1,Fa} << cnt.
    - cnt increments.
    - Leave for NORM when cnt==4 has been processed.
  - NORM: 1 cycle. Compute p and register it.
  - DONE: hold out_valid=1 and p stable. Go to IDLE on out_valid && out_ready.
- Arithmetic in NORM:
  - Sign s = Sa ^ Sb.
  - e = Ea + Eb - 3, computed as 5-bit signed.
  - If acc[9]: F = acc[8:5], e = e + 1.
  - Else: F = acc[7:4] (acc[8] is guaranteed set).
  - Truncation only, no rounding (matches the downstream adder).
  - e > 7: saturate, p = {s, 7'h7F}.
  - e < 0: flush, p = 8'h00.
  - Either operand zero (bits[6:0]==0): p = 8'h00, regardless of signs or computed e.
  - e==0 with F==0 encodes as zero. This is an accepted format limitation; p = {s,7'h00} is then forced to 8'h00.
- Operand inputs are ignored outside the accept cycle. Changes on a/b during MUL, NORM or DONE have no effect.

## Timing
- Reset (async assert, sync release through the flops):
  - state=IDLE, out_valid=0, p=8'h00, busy=0, in_ready=1.
  - Accumulator and counter are 0.
- in_ready and busy are combinational decodes of state. out_valid and p are registered.
- Latency: operands accepted at edge T0. MUL occupies cycles T0+1..T0+5, NORM is T0+6, and out_valid=1 from T0+7.
- Fixed latency of 7 cycles for all operands, including zero, overflow and underflow cases.
- Backpressure:
  - out_valid stays high and p does not change until out_ready is sampled high.
  - While waiting, in_ready stays 0.
- After the output handshake at edge Tk, IDLE is entered and in_ready=1 in cycle Tk+1. There is no same-cycle accept in DONE.
- Minimum initiation interval is 8 cycles.
- out_ready has no effect outside DONE. in_valid has no effect outside IDLE.
- Reset asserted in any state, including mid-MUL or in DONE:
  - Immediately returns to IDLE with out_valid=0 and p=8'h00.
  - The partial product is discarded and no output is produced for the aborted operation.

## Test plan
- Basic and latency, out_ready=1:
  - a=0x30 (1.0), b=0x30 -> p=0x30, out_valid exactly 7 cycles after accept.
  - a=0x38 (1.5), b=0x38 -> p=0x42 (2.25, carry path acc[9]).
- Sign: a=0xC0 (-2.0), b=0x48 (3.0) -> p=0xD8 (-6.0).
- Overflow, underflow and zero:
  - a=0x7F, b=0x7F -> p=0x7F (saturate).
  - a=0x10, b=0x10 -> p=0x00 (underflow flush).
  - a=0x80, b=0x48 -> p=0x00.
  - All with latency 7.
- Backpressure:
  - Hold out_ready=0 for 4 cycles after out_valid.
  - p stays constant, in_ready=0 and busy=1 throughout.
  - Raise out_ready: handshake happens, in_ready=1 next cycle.
  - Toggle a/b during MUL: no effect on p.
- Reset and back-to-back:
  - Pulse rst_n low during MUL cycle 3: out_valid=0, p=0x00, in_ready=1 immediately, no stale output afterwards.
  - Then stream 0x30×0x30 and 0x38×0x38 with in_valid held high: outputs 0x30 then 0x42, accepts 8 cycles apart.
